// File: rtl/fade_pkg.sv
// Shared types and helpers for the multi-channel LED fade engine.
package fade_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BREATHE = 2'd1,
        MODE_FREEZE  = 2'd2,
        MODE_ON      = 2'd3
    } mode_t;

    // Folds a phase in 0..2p-1 onto a triangle in 0..p-1.
    function automatic int unsigned tri_map(input int unsigned ph, input int unsigned p);
        return (ph < p) ? ph : (2 * p - 1 - ph);
    endfunction

endpackage

// File: rtl/multi_fade_if.sv
// Board-side bundle for the fade engine: mode select in, LED pins out.
interface multi_fade_if #(
    parameter int unsigned NUM_CH = 3
);
    import fade_pkg::*;

    mode_t             mode;
    logic [NUM_CH-1:0] LED;

    modport master (output mode, input LED);
    modport slave  (input mode, output LED);

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: latches its triangle duty once per period and compares it against the
// shared period counter.
module pwm_channel
    import fade_pkg::*;
#(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [CW-1:0] t_i,
    input  logic [CW-1:0] cnt,
    input  mode_t         mode,
    output logic          lit
);

    logic [CW-1:0] duty_q;

    // Reloaded only at the period boundary so the duty never changes mid-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
        end else if (tick) begin
            duty_q <= t_i;
        end
    end

    always_comb begin
        lit = 1'b0;
        unique case (mode)
            MODE_BREATHE, MODE_FREEZE: lit = (cnt < duty_q);
            MODE_ON:                   lit = 1'b1;
            default:                   lit = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_fade.sv
// Multi-channel LED fade engine: shared PWM period counter, stepped triangle phase and
// per-channel phase offsets so each channel breathes out of step with the others.
module multi_fade
    import fade_pkg::*;
#(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned STEP_PERIODS = 10,
    parameter int unsigned INC          = 4,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input logic        clk,
    input logic        rst,
    multi_fade_if.slave bus
);

    localparam int unsigned P   = PWM_INTERVAL;
    localparam int unsigned CW  = $clog2(P);
    localparam int unsigned PW  = $clog2(2 * P);
    localparam int unsigned PW1 = PW + 1;
    localparam int unsigned SW  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int unsigned OFS = (2 * P) / NUM_CH;

    logic [CW-1:0]     cnt;
    logic [SW-1:0]     step_cnt;
    logic [PW-1:0]     ph;
    logic              tick;
    logic              breathe;
    logic              step;
    logic [PW:0]       ph_sum;
    logic [NUM_CH-1:0] lit;

    assign tick    = (cnt == CW'(P - 1));
    assign breathe = (bus.mode == MODE_BREATHE);
    assign step    = tick && breathe && (step_cnt == SW'(STEP_PERIODS - 1));
    assign ph_sum  = {1'b0, ph} + PW1'(INC);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            step_cnt <= '0;
            ph       <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick && breathe) begin
                step_cnt <= step ? '0 : step_cnt + 1'b1;
            end
            if (step) begin
                ph <= (ph_sum >= PW1'(2 * P)) ? PW'(ph_sum - PW1'(2 * P)) : PW'(ph_sum);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [PW:0]   ph_ofs;
        logic [PW-1:0] ph_ch;
        logic [CW-1:0] t_ch;

        // Both operands are below 2P, so a single conditional subtract wraps the sum.
        assign ph_ofs = {1'b0, ph} + PW1'(i * OFS);
        assign ph_ch  = (ph_ofs >= PW1'(2 * P)) ? PW'(ph_ofs - PW1'(2 * P)) : PW'(ph_ofs);
        assign t_ch   = CW'(tri_map(32'(ph_ch), P));

        pwm_channel #(
            .CW(CW)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .tick(tick),
            .t_i (t_ch),
            .cnt (cnt),
            .mode(bus.mode),
            .lit (lit[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.LED <= {NUM_CH{ACTIVE_LOW}};
        end else begin
            bus.LED <= lit ^ {NUM_CH{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_multi_fade.sv
// Directed bench for multi_fade: a P=8 three-channel instance and a P=2 single-channel
// active-high corner instance sharing one clock.
module tb_multi_fade;
    import fade_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    multi_fade_if #(.NUM_CH(3)) bus_a ();
    multi_fade_if #(.NUM_CH(1)) bus_b ();

    multi_fade #(
        .PWM_INTERVAL(8),
        .NUM_CH      (3),
        .STEP_PERIODS(2),
        .INC         (1),
        .ACTIVE_LOW  (1'b1)
    ) dut_a (
        .clk(clk),
        .rst(rst_a),
        .bus(bus_a)
    );

    multi_fade #(
        .PWM_INTERVAL(2),
        .NUM_CH      (1),
        .STEP_PERIODS(2),
        .INC         (1),
        .ACTIVE_LOW  (1'b0)
    ) dut_b (
        .clk(clk),
        .rst(rst_b),
        .bus(bus_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int tri_ref(input int ph, input int p);
        return (ph < p) ? ph : (2 * p - 1 - ph);
    endfunction

    // Expected duty of the P=8 instance in period n after reset in uninterrupted BREATHE.
    function automatic int ramp_duty(input int n, input int ofs);
        if (n == 0) return 0;
        return tri_ref((((n - 1) / 2) + ofs) % 16, 8);
    endfunction

    function automatic int corner_duty(input int n);
        if (n == 0) return 0;
        return tri_ref(((n - 1) / 2) % 4, 2);
    endfunction

    // Observes one 8-cycle period; a channel whose lit cycles are not a prefix reads as 99.
    task automatic check_period(input string tag, input int n,
                                input int e0, input int e1, input int e2);
        int duty [3];
        bit gap  [3];
        int exp  [3];
        exp[0] = e0;
        exp[1] = e1;
        exp[2] = e2;
        for (int i = 0; i < 3; i++) begin
            duty[i] = 0;
            gap[i]  = 1'b0;
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (bus_a.LED[i] === 1'b0) begin
                    if (gap[i]) duty[i] = 99;
                    else if (duty[i] != 99) duty[i]++;
                end else begin
                    gap[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s p%0d ch%0d duty", tag, n, i), duty[i], exp[i]);
        end
    endtask

    initial begin
        int bad;
        rst_a      = 1'b1;
        rst_b      = 1'b1;
        bus_a.mode = MODE_OFF;
        bus_b.mode = MODE_OFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset led_a", bus_a.LED, 3'b111);
        check("reset led_b", bus_b.LED, 1'b0);

        rst_a      = 1'b0;
        bus_a.mode = MODE_BREATHE;
        for (int n = 0; n <= 40; n++) begin
            check_period("ramp", n, ramp_duty(n, 0), ramp_duty(n, 5), ramp_duty(n, 10));
        end

        // ph is 4 here with one more tick pending before the next step.
        bus_a.mode = MODE_FREEZE;
        for (int n = 41; n <= 60; n++) check_period("freeze", n, 4, 6, 1);

        bus_a.mode = MODE_BREATHE;
        check_period("resume", 61, 4, 6, 1);
        check_period("resume", 62, 4, 6, 1);
        check_period("resume", 63, 5, 5, 0);

        bus_a.mode = MODE_OFF;
        @(posedge clk);
        #1;
        check("override off", bus_a.LED, 3'b111);
        bus_a.mode = MODE_ON;
        @(posedge clk);
        #1;
        check("override on", bus_a.LED, 3'b000);
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus_a.LED !== 3'b000) bad++;
        end
        check("override on hold", bad, 0);

        bus_a.mode = MODE_BREATHE;
        check_period("post_ovr", 68, 6, 4, 0);
        check_period("post_ovr", 69, 6, 4, 0);
        check_period("post_ovr", 70, 6, 4, 0);
        check_period("post_ovr", 71, 7, 3, 1);

        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        check("mid reset led_a", bus_a.LED, 3'b111);
        rst_a = 1'b0;
        for (int n = 0; n <= 3; n++) begin
            check_period("rerun", n, ramp_duty(n, 0), ramp_duty(n, 5), ramp_duty(n, 10));
        end

        bus_b.mode = MODE_BREATHE;
        @(posedge clk);
        #1;
        check("corner reset overrides mode", bus_b.LED, 1'b0);
        rst_b = 1'b0;
        for (int k = 0; k < 36; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("corner p%0d c%0d", k / 2, k % 2), bus_b.LED,
                  ((k % 2) < corner_duty(k / 2)) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_fade.md
# multi_fade

Multi-channel LED fade engine with a selectable mode. One shared PWM period counter drives NUM_CH duty comparators. A triangle-wave brightness phase advances in fixed steps, and each channel sees the phase offset by an equal fraction of the cycle, so an RGB LED cycles hue while breathing. It sits directly under the board top level and drives the LED pins; the board top only ties off mode and instantiates it.

## Interface
- PWM_INTERVAL, 1200: clocks per PWM period (100 us at 12 MHz); must be ≥ 2.
- NUM_CH, 3: number of output channels; must be ≥ 1.
- STEP_PERIODS, 10: PWM periods per brightness step; must be ≥ 1.
- INC, 4: phase increment per step; must satisfy 1 ≤ INC < PWM_INTERVAL.
- ACTIVE_LOW, 1: 1 means the output pin is low when lit.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- mode  in  2  0 = OFF, 1 = BREATHE, 2 = FREEZE, 3 = ON; sampled every cycle.
- LED  out  NUM_CH  registered channel outputs.

## Operation
- Define P = PWM_INTERVAL, CW = $clog2(P), PW = $clog2(2P).
- Period counter cnt[CW]: counts 0..P-1 and wraps to 0. It runs in every mode. A tick is asserted in the cycle where cnt == P-1.
- Step counter: counts ticks from 0..STEP_PERIODS-1 in BREATHE only; it holds in other modes. A step is asserted on a tick when the step counter == STEP_PERIODS-1.
- Phase ph[PW], range 0..2P-1: on a step, ph ← ph+INC, minus 2P if the sum is ≥ 2P. ph only changes in BREATHE.
- Channel phase: OFS = (2P)/NUM_CH, integer divide. ph_i = ph + i·OFS, minus 2P if ≥ 2P. One conditional subtract is sufficient.
- Triangle mapping: t_i = ph_i when ph_i < P, otherwise 2P-1-ph_i. t_i is always in 0..P-1.
- Duty latch: duty_q[i] ← t_i on every tick, using the pre-update ph. This makes duty glitch-free within a period.
- Lit condition:
  - BREATHE/FREEZE: lit_i = (cnt < duty_q[i]).
  - OFF: lit_i = 0.
  - ON: lit_i = 1.
- Output: LED[i] ← lit_i XOR ACTIVE_LOW, registered.
- Mode behaviour:
  - FREEZE holds ph and the step counter; the duty latch keeps reloading the same value.
  - A return to BREATHE resumes from the held ph.
  - OFF and ON override the output only; ph is preserved.
- Reset state: cnt = 0, step counter = 0, ph = 0, all duty_q = 0, LED = {NUM_CH{ACTIVE_LOW}} (all unlit).

## Timing
- LED lags the cnt/mode compare by 1 cycle. A mode change is visible on LED in the cycle after it is sampled.
- A new duty takes effect at cnt = 0 of the period following the latching tick.
- The first period after reset is fully unlit, because duty_q = 0.
- ph moves once every STEP_PERIODS·P clocks in BREATHE. A full breathe cycle takes 2P/INC steps when INC divides 2P.
- Wrap-around: ph going 2P-1 → 0 is seamless. Duty is continuous across the wrap (0 → 0 region).
- rst asserted mid-period restores the reset state on the next edge; it overrides mode.
- A tick and a mode change in the same cycle: the duty latch still loads, and the step uses the mode sampled that cycle.

## Structure
- fade_pkg holds:
  - a typedef enum logic [1:0] mode_t with MODE_OFF, MODE_BREATHE, MODE_FREEZE, MODE_ON;
  - a function tri_map(ph, P) that returns the triangle value.
- Sub-module pwm_channel, instantiated NUM_CH times via generate. Its ports are clk, rst, tick, t_i, cnt, mode and lit. It owns duty_q and the compare.
- multi_fade owns cnt, the step counter, ph, the offset adders and the output register.

## Test plan
All scenarios use P = 8, NUM_CH = 3, STEP_PERIODS = 2, INC = 1 (OFS = 5) unless stated.
- Reset: hold rst for 3 cycles, then mode = BREATHE.
  - LED = 3'b111 throughout period 0.
  - Period 1: ch0 unlit; ch1 and ch2 lit (pin low) for cnt 0..4, with duty 5 on both.
- Breathe ramp: run 40 periods.
  - ch0 duty in period n (n ≥ 1) is tri(floor((n-1)/2) mod 16).
  - Period 17 gives duty 7, period 31 gives duty 0, period 33 gives duty 0 after the wrap.
- Freeze: switch to FREEZE when ph = 4.
  - ch0 duty stays at 4 for 20 periods.
  - On return to BREATHE, the next step gives ph = 5.
- Override: mode = OFF gives LED = 3'b111 one cycle later; mode = ON gives 3'b000 one cycle later.
  - ph is unchanged across both overrides.
- Mid-operation reset: assert rst at cnt = 3 in period 12.
  - The next cycle has cnt = 0, ph = 0 and LED = 3'b111.
  - Behaviour thereafter is identical to the reset scenario.
- Parameter corner: NUM_CH = 1, ACTIVE_LOW = 0, P = 2, INC = 1.
  - LED is 0 at reset.
  - The output follows the triangle 0,1,1,0 per step with active-high polarity.
